// File: rtl/pixel_cache_flush.sv
// Pixel-cache flush sequencer: walks the active bit planes of one cached row
// and writes each plane byte to game-pak RAM in character layout. A partially
// dirty row first reads each RAM byte and strobes it into the selected plane
// so clean pixels are merged before the write-back.
module pixel_cache_flush #(
    parameter int ADDR_W = 17,
    parameter int PLANES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        bpp_mode,
    input  logic [7:0]        dirty,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [7:0]        plane_data,
    output logic [2:0]        plane_sel,
    output logic [7:0]        ramd,
    output logic              ldram_n,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ram_ack,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, RD_REQ, MERGE, WR_REQ, NEXT, FIN} state_t;

    state_t            state, state_d;
    logic [2:0]        last_plane, last_plane_d;
    logic              partial, partial_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [2:0]        plane_sel_d;
    logic [7:0]        ramd_d;
    logic              ldram_n_d;
    logic              ram_req_d;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [7:0]        ram_wdata_d;
    logic              busy_d;
    logic              done_d;

    // Plane pairs are interleaved bytes; each pair advances 16 bytes.
    function automatic logic [ADDR_W-1:0] plane_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [2:0] p);
        return base + ADDR_W'({p[2:1], 3'b000, p[0]});
    endfunction

    // Index of the last plane in use for a colour depth; mode 2 behaves as 4bpp.
    function automatic logic [2:0] mode_last(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd3:    return 3'(PLANES - 1);
            default: return 3'd3;
        endcase
    endfunction

    // State register together with every registered output and latched request field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_plane <= 3'd0;
            partial    <= 1'b0;
            base_q     <= '0;
            plane_sel  <= 3'd0;
            ramd       <= 8'd0;
            ldram_n    <= 1'b1;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            last_plane <= last_plane_d;
            partial    <= partial_d;
            base_q     <= base_d;
            plane_sel  <= plane_sel_d;
            ramd       <= ramd_d;
            ldram_n    <= ldram_n_d;
            ram_req    <= ram_req_d;
            ram_we     <= ram_we_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state selection; acks only count while a request is outstanding.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dirty == 8'h00)      state_d = FIN;
                    else if (dirty == 8'hFF) state_d = WR_REQ;
                    else                     state_d = RD_REQ;
                end
            end
            RD_REQ:  if (ram_req && ram_ack) state_d = MERGE;
            MERGE:   state_d = WR_REQ;
            WR_REQ:  if (ram_req && ram_ack) state_d = NEXT;
            NEXT: begin
                if (plane_sel == last_plane) state_d = FIN;
                else if (partial)            state_d = RD_REQ;
                else                         state_d = WR_REQ;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; a request opens on entry to an access
    // and closes on its ack, so req is always low at least one cycle between accesses.
    always_comb begin
        last_plane_d = last_plane;
        partial_d    = partial;
        base_d       = base_q;
        plane_sel_d  = plane_sel;
        ramd_d       = ramd;
        ldram_n_d    = 1'b1;
        ram_req_d    = ram_req;
        ram_we_d     = ram_we;
        ram_addr_d   = ram_addr;
        ram_wdata_d  = ram_wdata;
        busy_d       = busy;
        done_d       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    last_plane_d = mode_last(bpp_mode);
                    partial_d    = (dirty != 8'hFF);
                    base_d       = row_base;
                    plane_sel_d  = 3'd0;
                    busy_d       = 1'b1;
                    if (dirty == 8'h00) begin
                        done_d = 1'b1;
                    end else if (dirty != 8'hFF) begin
                        ram_req_d  = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = plane_addr(row_base, 3'd0);
                    end
                end
            end
            RD_REQ: begin
                if (ram_req && ram_ack) begin
                    ramd_d    = ram_rdata;
                    ram_req_d = 1'b0;
                    ldram_n_d = 1'b0;
                end
            end
            WR_REQ: begin
                if (!ram_req) begin
                    // plane_data already reflects the merge strobed in MERGE
                    ram_wdata_d = plane_data;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = plane_addr(base_q, plane_sel);
                end else if (ram_ack) begin
                    ram_req_d = 1'b0;
                end
            end
            NEXT: begin
                if (plane_sel == last_plane) begin
                    done_d = 1'b1;
                end else begin
                    plane_sel_d = plane_sel + 3'd1;
                    if (partial) begin
                        ram_req_d  = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = plane_addr(base_q, plane_sel + 3'd1);
                    end
                end
            end
            FIN: busy_d = 1'b0;
            default: ;
        endcase
    end

endmodule
